store_byte_serializer: RTL and testbench
========================================

# store_byte_serializer

Store-path counterpart of the load sign-extension logic in the 32-bit MIPS datapath: it narrows a 32-bit register value to the byte, halfword or word selected by SB/SH/SW and writes it to an 8-bit-wide data-memory port one byte per accepted beat. It sits between the EX/MEM store request and the byte-wide data RAM. It enforces MIPS alignment and stalls the pipeline through a valid/ready handshake.

## Interface
Parameters:
- ADDR_W, 32: width of the request and memory addresses.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  store request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_addr  in  ADDR_W  byte address of the store.
- req_data  in  32  source register value.
- req_size  in  2  00 = SB, 01 = SH, 10 = SW, 11 = reserved.
- mem_we  out  1  byte write valid.
- mem_addr  out  ADDR_W  byte address of the current beat.
- mem_wdata  out  8  byte of the current beat.
- mem_ack  in  1  memory accepts the beat in this cycle when mem_we is high.
- done  out  1  one-cycle pulse: store completed.
- misaligned  out  1  one-cycle pulse: store rejected, no memory write.

## Operation
- States: IDLE, WRITE, RESP.
- IDLE: req_ready = 1. On req_valid the block latches addr, data and size.
- Alignment rules:
  - SH requires addr[0] = 0.
  - SW requires addr[1:0] = 00.
  - Size 11 is always an error.
- Error path: go to RESP with err flag set. No beat is issued.
- OK path: go to WRITE with beat index idx = 0 and last = 0, 1 or 3 for SB, SH or SW.
- WRITE: mem_we = 1, mem_addr = base + idx (modulo 2^ADDR_W).
- Byte order is big-endian; the lowest address receives the most significant byte:
  - SB: data[7:0].
  - SH: idx 0 = data[15:8], idx 1 = data[7:0].
  - SW: idx 0 = data[31:24], idx 1 = data[23:16], idx 2 = data[15:8], idx 3 = data[7:0].
- While mem_ack = 0, mem_addr and mem_wdata hold stable. On mem_ack, idx increments.
- On mem_ack at idx = last, go to RESP.
- RESP: drive done = 1 (OK) or misaligned = 1 (error) for exactly one cycle, then go to IDLE. req_ready = 0 in RESP.
- Aligned requests never cross the top of the address space. The modular add is still specified.
- req_* inputs are ignored outside IDLE. The latched copy is authoritative for the whole transaction.

## Timing
- Reset values: state IDLE, req_ready 1, mem_we 0, mem_addr 0, mem_wdata 0, done 0, misaligned 0, idx 0.
- Reset mid-transaction returns the block to IDLE at once; mem_we drops asynchronously. Bytes already acked stay written, with no rollback. No done or misaligned pulse is produced for the aborted store.
- Latency with mem_ack tied high, request accepted at edge T:
  - Beats in cycles T+1 … T+N (N = 1, 2 or 4).
  - done in cycle T+N+1.
  - req_ready high again in cycle T+N+2.
- Misaligned request accepted at edge T: misaligned pulses in cycle T+1, req_ready high in T+2, mem_we never asserted.
- Each wait cycle (mem_ack = 0) adds exactly one cycle. There are no other stalls.
- Throughput: one SW per 6 cycles at best, one SB per 3.

## Structure
- Shared package store_pkg:
  - size enum {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD}.
  - State enum {ST_IDLE, ST_WRITE, ST_RESP}.
  - Function beat_count(size).
  - Function select_byte(data, size, idx), implementing the big-endian lane mapping above.
- No sub-module. Byte selection is a package function and the FSM is small enough for a single module.

## Test plan
- SW addr 0x0000_1000, data 0xDEAD_BEEF, ack tied 1:
  - Beats (0x1000, DE), (0x1001, AD), (0x1002, BE), (0x1003, EF).
  - done in cycle 5 after acceptance.
- SH addr 0x0000_0202, data 0x1234_5678, ack low for 2 cycles on beat 0:
  - Beat 0 holds (0x202, 56) for 3 cycles, then (0x203, 78).
  - Single done pulse.
- SB addr 0x0000_0007, data 0xFFFF_FFA5: one beat (0x7, A5); done 2 cycles after acceptance.
- Misaligned requests: SW addr 0x0000_0002, SH addr 0x0000_0001, and size 11.
  - Each gives misaligned pulse in the next cycle.
  - mem_we stays 0 and done stays 0.
- Reset during SW after beat 1 is acked: mem_we drops immediately and no done pulse appears. After release, req_ready = 1 and a new SB completes normally.
- Back-to-back requests with req_valid held high and changing req_data mid-transaction: the first store uses its latched data, and the second is accepted only once req_ready returns.

Source files
------------

// File: rtl/store_pkg.sv
// Shared types and helpers for the store byte serializer: size and state
// encodings, beat count per store size, and the big-endian byte-lane select.
package store_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_WRITE = 2'b01,
      ST_RESP  = 2'b10
   } state_e;

   // Number of byte beats a store of the given size produces (0 for reserved).
   function automatic logic [2:0] beat_count(input size_e size);
      logic [2:0] n;
      case (size)
         SZ_BYTE: n = 3'd1;
         SZ_HALF: n = 3'd2;
         SZ_WORD: n = 3'd4;
         default: n = 3'd0;
      endcase
      return n;
   endfunction

   // Byte for beat idx; beat 0 (lowest address) carries the most significant
   // byte of the stored quantity.
   function automatic logic [7:0] select_byte(input logic [31:0] data,
                                              input size_e       size,
                                              input logic [1:0]  idx);
      logic [2:0] last;
      logic [1:0] lane;
      logic [7:0] b;
      last = beat_count(size) - 3'd1;
      lane = last[1:0] - idx;
      case (lane)
         2'd0:    b = data[7:0];
         2'd1:    b = data[15:8];
         2'd2:    b = data[23:16];
         default: b = data[31:24];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/store_byte_serializer.sv
// Narrows a 32-bit store (SB/SH/SW) into byte beats on an 8-bit memory port,
// rejecting misaligned requests with a one-cycle misaligned pulse.
module store_byte_serializer
   import store_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_data,
   input  logic [1:0]        req_size,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic              mem_ack,
   output logic              done,
   output logic              misaligned
);

   state_e            state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   logic [1:0]        last_q, last_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [31:0]       data_q, data_d;
   size_e             size_q, size_d;
   logic              err_q, err_d;

   size_e             req_size_e;
   logic              req_err;
   logic [2:0]        req_last;

   // Decode the incoming request: alignment check and index of final beat.
   always_comb begin
      req_size_e = size_e'(req_size);
      req_err    = (req_size_e == SZ_RSVD) ||
                   (req_size_e == SZ_HALF && req_addr[0]) ||
                   (req_size_e == SZ_WORD && (req_addr[1:0] != 2'b00));
      req_last   = beat_count(req_size_e) - 3'd1;
   end

   // Next-state logic: latch in IDLE, step beats on ack, pulse response once.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      last_d  = last_q;
      base_d  = base_q;
      data_d  = data_q;
      size_d  = size_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               base_d  = req_addr;
               data_d  = req_data;
               size_d  = req_size_e;
               err_d   = req_err;
               idx_d   = 2'd0;
               last_d  = req_err ? 2'd0 : req_last[1:0];
               state_d = req_err ? ST_RESP : ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (mem_ack) begin
               if (idx_q == last_q) begin
                  state_d = ST_RESP;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            idx_d   = 2'd0;
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = 2'd0;
         end
      endcase
   end

   // State and latched request registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= 2'd0;
         last_q  <= 2'd0;
         base_q  <= '0;
         data_q  <= 32'd0;
         size_q  <= SZ_BYTE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         base_q  <= base_d;
         data_q  <= data_d;
         size_q  <= size_d;
         err_q   <= err_d;
      end
   end

   // Outputs decoded from state so a reset drops mem_we without waiting a clock.
   always_comb begin
      req_ready  = (state_q == ST_IDLE);
      mem_we     = (state_q == ST_WRITE);
      mem_addr   = '0;
      mem_wdata  = 8'd0;
      done       = (state_q == ST_RESP) && !err_q;
      misaligned = (state_q == ST_RESP) && err_q;
      if (state_q == ST_WRITE) begin
         // Address wraps modulo 2^ADDR_W.
         mem_addr  = base_q + {{(ADDR_W-2){1'b0}}, idx_q};
         mem_wdata = select_byte(data_q, size_q, idx_q);
      end
   end

endmodule

// File: tb/tb_store_byte_serializer.sv
// Directed testbench for store_byte_serializer. All activity happens on the
// falling clock edge; the DUT samples on the rising edge.
module tb_store_byte_serializer;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic [1:0]  req_size;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_ack;
   logic        done;
   logic        misaligned;

   int checks = 0;
   int errors = 0;

   store_byte_serializer #(.ADDR_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .req_size   (req_size),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .done       (done),
      .misaligned (misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_addr  = 32'd0;
      req_data  = 32'd0;
      req_size  = 2'd0;
      mem_ack   = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", mem_we); end
      checks++; if (mem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr got %h exp 0", mem_addr); end
      checks++; if (mem_wdata !== 8'd0) begin errors++; $display("FAIL reset_wdata got %h exp 0", mem_wdata); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis got %b exp 0", misaligned); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_sw;
      logic [7:0] exp_b [4];
      exp_b[0] = 8'hDE; exp_b[1] = 8'hAD; exp_b[2] = 8'hBE; exp_b[3] = 8'hEF;
      mem_ack   = 1'b1;
      req_addr  = 32'h0000_1000;
      req_data  = 32'hDEAD_BEEF;
      req_size  = 2'b10;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL sw_we beat %0d got %b exp 1", i, mem_we); end
         checks++; if (mem_addr !== 32'h1000 + i) begin errors++; $display("FAIL sw_addr beat %0d got %h exp %h", i, mem_addr, 32'h1000 + i); end
         checks++; if (mem_wdata !== exp_b[i]) begin errors++; $display("FAIL sw_data beat %0d got %h exp %h", i, mem_wdata, exp_b[i]); end
         checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL sw_busy beat %0d got %b exp 0", i, req_ready); end
         @(negedge clk);
      end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL sw_done got %b exp 1", done); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL sw_we_resp got %b exp 0", mem_we); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL sw_ready_resp got %b exp 0", req_ready); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL sw_done_clr got %b exp 0", done); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL sw_ready_back got %b exp 1", req_ready); end
   endtask

   task automatic test_sh_wait;
      int done_cnt;
      done_cnt  = 0;
      mem_ack   = 1'b0;
      req_addr  = 32'h0000_0202;
      req_data  = 32'h1234_5678;
      req_size  = 2'b01;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h202 || mem_wdata !== 8'h56) begin
            errors++; $display("FAIL sh_hold cyc %0d got we=%b %h/%h exp 1 00000202/56", i, mem_we, mem_addr, mem_wdata);
         end
         if (done) done_cnt++;
         if (i == 2) mem_ack = 1'b1;
         @(negedge clk);
      end
      checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h203 || mem_wdata !== 8'h78) begin
         errors++; $display("FAIL sh_beat1 got we=%b %h/%h exp 1 00000203/78", mem_we, mem_addr, mem_wdata);
      end
      if (done) done_cnt++;
      @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL sh_done got %b exp 1", done); end
      for (int i = 0; i < 3; i++) begin
         if (done) done_cnt++;
         @(negedge clk);
      end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL sh_done_count got %0d exp 1", done_cnt); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL sh_ready got %b exp 1", req_ready); end
   endtask

   task automatic test_sb;
      mem_ack   = 1'b1;
      req_addr  = 32'h0000_0007;
      req_data  = 32'hFFFF_FFA5;
      req_size  = 2'b00;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h7 || mem_wdata !== 8'hA5) begin
         errors++; $display("FAIL sb_beat got we=%b %h/%h exp 1 00000007/a5", mem_we, mem_addr, mem_wdata);
      end
      @(negedge clk);
      checks++; if (done !== 1'b1 || mem_we !== 1'b0) begin
         errors++; $display("FAIL sb_done got done=%b we=%b exp 1 0", done, mem_we);
      end
      @(negedge clk);
      checks++; if (req_ready !== 1'b1 || done !== 1'b0) begin
         errors++; $display("FAIL sb_idle got ready=%b done=%b exp 1 0", req_ready, done);
      end
   endtask

   task automatic test_misaligned;
      logic [1:0]  sz [3];
      logic [31:0] ad [3];
      sz[0] = 2'b10; ad[0] = 32'h0000_0002;
      sz[1] = 2'b01; ad[1] = 32'h0000_0001;
      sz[2] = 2'b11; ad[2] = 32'h0000_0000;
      mem_ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         req_addr  = ad[k];
         req_size  = sz[k];
         req_data  = 32'hCAFE_F00D;
         req_valid = 1'b1;
         @(negedge clk);
         req_valid = 1'b0;
         checks++; if (misaligned !== 1'b1 || done !== 1'b0 || mem_we !== 1'b0) begin
            errors++; $display("FAIL mis_pulse case %0d got mis=%b done=%b we=%b exp 1 0 0", k, misaligned, done, mem_we);
         end
         @(negedge clk);
         checks++; if (misaligned !== 1'b0 || req_ready !== 1'b1 || mem_we !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mis_after case %0d got mis=%b ready=%b we=%b done=%b exp 0 1 0 0",
                               k, misaligned, req_ready, mem_we, done);
         end
      end
   endtask

   task automatic test_reset_mid;
      int stray;
      stray     = 0;
      mem_ack   = 1'b1;
      req_addr  = 32'h0000_0040;
      req_data  = 32'h0102_0304;
      req_size  = 2'b10;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h42 || mem_wdata !== 8'h03) begin
         errors++; $display("FAIL rmid_beat2 got we=%b %h/%h exp 1 00000042/03", mem_we, mem_addr, mem_wdata);
      end
      rst_n = 1'b0;
      #1;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rmid_we_async got %b exp 0", mem_we); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done || misaligned) stray++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (done || misaligned || mem_we) stray++;
      end
      checks++; if (stray !== 0) begin errors++; $display("FAIL rmid_no_pulse got %0d stray exp 0", stray); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b exp 1", req_ready); end
      req_addr  = 32'h0000_0010;
      req_data  = 32'h0000_0033;
      req_size  = 2'b00;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 8'h33) begin
         errors++; $display("FAIL rmid_sb_beat got we=%b %h/%h exp 1 00000010/33", mem_we, mem_addr, mem_wdata);
      end
      @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL rmid_sb_done got %b exp 1", done); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      logic [7:0] exp_b [4];
      exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
      mem_ack   = 1'b1;
      req_addr  = 32'h0000_0100;
      req_data  = 32'h1122_3344;
      req_size  = 2'b10;
      req_valid = 1'b1;
      @(negedge clk);
      // Second request presented while the first is still in flight.
      req_addr = 32'h0000_0200;
      req_data = 32'hAABB_CCDD;
      for (int i = 0; i < 4; i++) begin
         checks++; if (mem_addr !== 32'h100 + i || mem_wdata !== exp_b[i] || req_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_first beat %0d got %h/%h ready=%b exp %h/%h 0",
                               i, mem_addr, mem_wdata, req_ready, 32'h100 + i, exp_b[i]);
         end
         @(negedge clk);
      end
      checks++; if (done !== 1'b1 || req_ready !== 1'b0) begin
         errors++; $display("FAIL b2b_done got done=%b ready=%b exp 1 0", done, req_ready);
      end
      @(negedge clk);
      checks++; if (req_ready !== 1'b1 || mem_we !== 1'b0) begin
         errors++; $display("FAIL b2b_ready got ready=%b we=%b exp 1 0", req_ready, mem_we);
      end
      @(negedge clk);
      req_valid = 1'b0;
      checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 8'hAA) begin
         errors++; $display("FAIL b2b_second got we=%b %h/%h exp 1 00000200/aa", mem_we, mem_addr, mem_wdata);
      end
      repeat (4) @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_second_done got %b exp 1", done); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_sw();
      test_sh_wait();
      test_sb();
      test_misaligned();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
